// File: rtl/forwarding_hazard_unit.sv
// EX-stage forwarding select and load-use hazard unit.
// Tracks register-write tags for the EX, MEM and WB slots. Drives the ALU operand
// forwarding selects for the instruction in EX. Stalls ID when it needs the result
// of a load that is still in EX.
module forwarding_hazard_unit #(
  parameter int unsigned REG_ADDR_W         = 3,
  parameter bit          ZERO_REG_HARDWIRED = 1'b0,
  parameter int unsigned LOAD_STALL_CYCLES  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_r1Address,
  input  logic [REG_ADDR_W-1:0] id_r2Address,
  input  logic                  id_useR1,
  input  logic                  id_useR2,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  id_regWrite,
  input  logic                  id_memRead,
  input  logic                  flush,
  output logic                  stall,
  output logic                  ex_bubble,
  output logic [1:0]            aluInputAForwardingSel,
  output logic [1:0]            aluInputBForwardingSel
);

  typedef enum logic {RUN, HOLD} state_t;

  localparam logic [1:0] CNT_INIT = 2'(LOAD_STALL_CYCLES - 1);
  localparam bit         HOLD_EN  = (LOAD_STALL_CYCLES > 1);

  state_t                state, state_next;
  logic [1:0]            cnt, cnt_next;

  logic                  ex_valid, ex_rw, ex_mr, ex_u1, ex_u2;
  logic [REG_ADDR_W-1:0] ex_dest, ex_r1, ex_r2;
  logic                  mem_valid, mem_rw, mem_mr;
  logic [REG_ADDR_W-1:0] mem_dest;
  logic                  wb_valid, wb_rw;
  logic [REG_ADDR_W-1:0] wb_dest;

  logic                  hz;
  logic                  take;

  function automatic logic match(input logic v, input logic rw,
                                 input logic [REG_ADDR_W-1:0] dest,
                                 input logic [REG_ADDR_W-1:0] src);
    return v & rw & (dest == src) & (!ZERO_REG_HARDWIRED | (src != '0));
  endfunction

  function automatic logic [1:0] fwd_sel(input logic use_src,
                                         input logic [REG_ADDR_W-1:0] src);
    if (use_src & match(mem_valid, mem_rw, mem_dest, src) & !mem_mr)
      return 2'b01;
    else if (use_src & match(wb_valid, wb_rw, wb_dest, src))
      return 2'b10;
    else
      return 2'b00;
  endfunction

  // Load-use hazard: the ID instruction needs a load result that is still in EX
  always_comb begin
    hz = id_valid & (((id_useR1 & match(ex_valid, ex_rw, ex_dest, id_r1Address))
                     | (id_useR2 & match(ex_valid, ex_rw, ex_dest, id_r2Address)))
                     & ex_mr);
  end

  // Stall FSM next state and outputs; flush overrides any stall and aborts HOLD
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    stall      = 1'b0;
    if (flush) begin
      state_next = RUN;
      cnt_next   = '0;
    end else begin
      case (state)
        RUN: begin
          stall = hz;
          if (hz) begin
            cnt_next   = CNT_INIT;
            state_next = HOLD_EN ? HOLD : RUN;
          end
        end
        HOLD: begin
          stall    = 1'b1;
          cnt_next = cnt - 2'd1;
          if (cnt == 2'd1) state_next = RUN;
        end
        default: state_next = RUN;
      endcase
    end
  end

  // Stall FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  assign take = id_valid & !flush & !stall;

  // Pipeline tag slots: ID -> EX (or bubble) -> MEM -> WB
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid  <= 1'b0;
      ex_rw     <= 1'b0;
      ex_mr     <= 1'b0;
      ex_u1     <= 1'b0;
      ex_u2     <= 1'b0;
      ex_dest   <= '0;
      ex_r1     <= '0;
      ex_r2     <= '0;
      mem_valid <= 1'b0;
      mem_rw    <= 1'b0;
      mem_mr    <= 1'b0;
      mem_dest  <= '0;
      wb_valid  <= 1'b0;
      wb_rw     <= 1'b0;
      wb_dest   <= '0;
    end else begin
      wb_valid  <= mem_valid;
      wb_rw     <= mem_rw;
      wb_dest   <= mem_dest;
      mem_valid <= ex_valid;
      mem_rw    <= ex_rw;
      mem_mr    <= ex_mr;
      mem_dest  <= ex_dest;
      ex_valid  <= take;
      ex_rw     <= take & id_regWrite;
      ex_mr     <= take & id_memRead;
      ex_u1     <= take & id_useR1;
      ex_u2     <= take & id_useR2;
      ex_dest   <= take ? id_dest      : '0;
      ex_r1     <= take ? id_r1Address : '0;
      ex_r2     <= take ? id_r2Address : '0;
    end
  end

  // Operand forwarding selects for the EX instruction; a load in MEM is never forwarded
  always_comb begin
    aluInputAForwardingSel = fwd_sel(ex_u1, ex_r1);
    aluInputBForwardingSel = fwd_sel(ex_u2, ex_r2);
  end

  assign ex_bubble = !ex_valid;

endmodule
